core_sequencer: RTL and testbench



---
 rtl/core_sequencer_pkg.sv | 19 +
 rtl/core_sequencer_if.sv | 21 ++
 rtl/core_sequencer_wait_timer.sv | 37 +++
 rtl/core_sequencer.sv | 131 +++++++++++++
 tb/tb_core_sequencer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, default HALT opcode
// and the watchdog counter width.
package core_sequencer_pkg;

    // FETCH..WRITE_BACK keep the old 2-bit phase values in the low bits; bit 2 marks the inactive states
    typedef enum logic [2:0] {
        ST_FETCH      = 3'd0,
        ST_DECODE     = 3'd1,
        ST_EXECUTE    = 3'd2,
        ST_WRITE_BACK = 3'd3,
        ST_IDLE       = 3'd4,
        ST_HALTED     = 3'd5,
        ST_FAULT      = 3'd6
    } seq_state_e;

    localparam int unsigned HALT_OP_DEFAULT = 31;
    localparam int unsigned WAIT_W          = 8;

endpackage

// File: rtl/core_sequencer_if.sv
// Handshake bundle between the sequencer (master) and the instruction memory / execute unit (slave).
interface core_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             imem_req;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_data;
    logic             exec_start;
    logic             exec_done;
    logic             wb_suppress;

    modport master (
        output imem_req, exec_start,
        input  imem_ack, imem_data, exec_done, wb_suppress
    );

    modport slave (
        input  imem_req, exec_start,
        output imem_ack, imem_data, exec_done, wb_suppress
    );
endinterface

// File: rtl/core_sequencer_wait_timer.sv
// Fetch watchdog: counts un-acknowledged FETCH cycles and flags the one that reaches MAX_WAIT.
module seq_wait_timer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + WAIT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Combinational so the caller can let a same-cycle ack take priority
    assign expired_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/core_sequencer.sv
// Instruction sequencer: FETCH/DECODE/EXECUTE/WRITE_BACK with run control, fetch watchdog and HALT.
// Define CORE_SEQ_PERF_EN to build the cycle/retired performance counters; otherwise they read 0.
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned OP_HI    = 31,
    parameter int unsigned OP_LO    = 27,
    parameter int unsigned HALT_OP  = HALT_OP_DEFAULT,
    parameter int unsigned MAX_WAIT = 16,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    core_sequencer_if.master  bus,
    output logic [WIDTH-1:0]  inst,
    output logic              pc_enable,
    output logic              wb_enable,
    output logic [2:0]        state,
    output logic              halted,
    output logic              fault,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retired_cnt
);
    localparam int unsigned      OP_W   = OP_HI - OP_LO + 1;
    localparam logic [OP_W-1:0]  HALT_V = OP_W'(HALT_OP);

    seq_state_e        state_q;
    logic              run_q;
    logic              exec_start_q;
    logic              exit_q;
    logic [WIDTH-1:0]  inst_q;
    logic              expired;

    seq_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .clr_i     (state_q != ST_FETCH),
        .en_i      ((state_q == ST_FETCH) && !bus.imem_ack),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            exec_start_q <= 1'b0;
            exit_q       <= 1'b0;
            inst_q       <= '0;
        end else begin
            run_q        <= run;
            exec_start_q <= 1'b0;
            exit_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (run) state_q <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (bus.imem_ack) begin
                        inst_q  <= bus.imem_data;
                        state_q <= ST_DECODE;
                    end else if (expired) begin
                        state_q <= ST_FAULT;
                    end
                end
                ST_DECODE: begin
                    if (inst_q[OP_HI:OP_LO] == HALT_V) begin
                        state_q <= ST_HALTED;
                    end else begin
                        state_q      <= ST_EXECUTE;
                        exec_start_q <= 1'b1;
                    end
                end
                ST_EXECUTE: begin
                    if (bus.exec_done) state_q <= ST_WRITE_BACK;
                end
                ST_WRITE_BACK: begin
                    state_q <= run ? ST_FETCH : ST_IDLE;
                end
                ST_HALTED: begin
                    // A run rising edge buys one extra HALTED cycle carrying pc_enable to skip the HALT word
                    if (exit_q) begin
                        state_q <= ST_FETCH;
                    end else if (run && !run_q) begin
                        exit_q <= 1'b1;
                    end
                end
                ST_FAULT: begin
                    state_q <= ST_FAULT;
                end
                default: begin
                    state_q <= ST_FAULT;
                end
            endcase
        end
    end

    assign bus.imem_req   = (state_q == ST_FETCH);
    assign bus.exec_start = exec_start_q;
    assign pc_enable      = (state_q == ST_WRITE_BACK) || exit_q;
    assign wb_enable      = (state_q == ST_WRITE_BACK) && !bus.wb_suppress;
    assign inst           = inst_q;
    assign state          = state_q;
    assign halted         = (state_q == ST_HALTED);
    assign fault          = (state_q == ST_FAULT);

`ifdef CORE_SEQ_PERF_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            if (!state_q[2]) cycle_q <= cycle_q + CNT_W'(1);
            if (state_q == ST_WRITE_BACK) retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_q;
    assign retired_cnt = retired_q;
`else
    assign cycle_cnt   = '0;
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: per-instruction timing and counter expectations
// are derived from handshake delays with plain arithmetic.
module tb_core_sequencer;
    localparam int unsigned MAXW     = 4;
    localparam logic [4:0]  HALT_OPC = 5'h1F;
    localparam logic [2:0]  S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_WB = 3'd3;
    localparam logic [2:0]  S_IDLE = 3'd4, S_HALTED = 3'd5, S_FAULT = 3'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] inst;
    logic        pc_enable, wb_enable, halted, fault;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, retired_cnt;

    int errors = 0;
    int checks = 0;
    int unsigned exp_cycles = 0;
    int unsigned exp_retired = 0;

    core_sequencer_if #(.WIDTH(32)) bus_if ();

    core_sequencer #(
        .WIDTH(32), .OP_HI(31), .OP_LO(27), .HALT_OP(31), .MAX_WAIT(MAXW), .CNT_W(32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .bus         (bus_if),
        .inst        (inst),
        .pc_enable   (pc_enable),
        .wb_enable   (wb_enable),
        .state       (state),
        .halted      (halted),
        .fault       (fault),
        .cycle_cnt   (cycle_cnt),
        .retired_cnt (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_cnt(input int unsigned v);
`ifdef CORE_SEQ_PERF_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:27] == HALT_OPC) w[27] = ~w[27];
        return w;
    endfunction

    task automatic do_reset();
        reset = 1'b1; run = 1'b0;
        bus_if.imem_ack = 1'b0; bus_if.exec_done = 1'b0; bus_if.wb_suppress = 1'b0;
        tick();
        reset = 1'b0;
        exp_cycles = 0; exp_retired = 0;
    endtask

    // Runs one non-HALT instruction starting from a sampled first FETCH cycle
    task automatic run_instr(input int unsigned ack_d, input int unsigned ex_d,
                             input logic supp, input logic [31:0] data, input logic drop_run);
        bus_if.wb_suppress = supp;
        for (int i = 0; i <= int'(ack_d); i++) begin
            checks++;
            if ({state, bus_if.imem_req, pc_enable} !== {S_FETCH, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL fetch_phase: got state=%0d req=%b pc_en=%b want state=0 req=1 pc_en=0",
                         state, bus_if.imem_req, pc_enable);
            end
            bus_if.imem_ack  = (i == int'(ack_d));
            bus_if.imem_data = (i == int'(ack_d)) ? data : $urandom;
            bus_if.exec_done = 1'($urandom);
            tick();
        end
        bus_if.imem_ack  = 1'b0;
        bus_if.imem_data = $urandom;
        exp_cycles += ack_d + 1;
        checks++;
        if ({state, inst} !== {S_DECODE, data}) begin
            errors++;
            $display("FAIL decode: got state=%0d inst=%h want state=1 inst=%h", state, inst, data);
        end
        tick();
        exp_cycles++;
        for (int j = 0; j <= int'(ex_d); j++) begin
            checks++;
            if ({state, bus_if.exec_start} !== {S_EXEC, (j == 0)}) begin
                errors++;
                $display("FAIL execute: got state=%0d start=%b want state=2 start=%b",
                         state, bus_if.exec_start, (j == 0));
            end
            if (drop_run && j == 0) run = 1'b0;
            bus_if.exec_done = (j == int'(ex_d));
            tick();
        end
        bus_if.exec_done = 1'b0;
        exp_cycles += ex_d + 1;
        checks++;
        if ({state, pc_enable, wb_enable, retired_cnt} !== {S_WB, 1'b1, !supp, exp_cnt(exp_retired)}) begin
            errors++;
            $display("FAIL writeback: got state=%0d pc=%b wb=%b ret=%0d want state=3 pc=1 wb=%b ret=%0d",
                     state, pc_enable, wb_enable, retired_cnt, !supp, exp_cnt(exp_retired));
        end
        tick();
        exp_cycles++;
        exp_retired++;
        checks++;
        if ({state, cycle_cnt, retired_cnt} !== {(run ? S_FETCH : S_IDLE), exp_cnt(exp_cycles), exp_cnt(exp_retired)}) begin
            errors++;
            $display("FAIL retire: got state=%0d cyc=%0d ret=%0d want state=%0d cyc=%0d ret=%0d",
                     state, cycle_cnt, retired_cnt, (run ? S_FETCH : S_IDLE), exp_cnt(exp_cycles), exp_cnt(exp_retired));
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; run = 1'b0;
        bus_if.imem_ack = 1'b0; bus_if.exec_done = 1'b0; bus_if.wb_suppress = 1'b0;
        bus_if.imem_data = '0;
        tick();
        tick();
        checks++;
        if ({state, inst, bus_if.imem_req, bus_if.exec_start, pc_enable, wb_enable, halted, fault, cycle_cnt, retired_cnt}
            !== {S_IDLE, 32'd0, 6'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_state: got state=%0d inst=%h req=%b st=%b pc=%b wb=%b h=%b f=%b cyc=%0d ret=%0d want idle/all zero",
                     state, inst, bus_if.imem_req, bus_if.exec_start, pc_enable, wb_enable, halted, fault, cycle_cnt, retired_cnt);
        end
        reset = 1'b0;
        exp_cycles = 0; exp_retired = 0;
        tick();
        checks++;
        if (state !== S_IDLE) begin
            errors++;
            $display("FAIL idle_hold: got state=%0d want %0d", state, S_IDLE);
        end
    endtask

    task automatic test_min_instr();
        do_reset();
        run = 1'b1;
        tick();
        run_instr(0, 0, 1'b0, rand_word(), 1'b0);
    endtask

    task automatic test_delayed();
        run_instr(MAXW - 1, 1, 1'b1, rand_word(), 1'b0);
    endtask

    task automatic test_random();
        repeat (20) begin
            run_instr($urandom_range(0, MAXW - 1), $urandom_range(0, 4), 1'($urandom), rand_word(), 1'b0);
        end
    endtask

    task automatic test_pause();
        run_instr($urandom_range(0, MAXW - 1), $urandom_range(0, 3), 1'b0, rand_word(), 1'b1);
        repeat (3) tick();
        checks++;
        if ({state, cycle_cnt} !== {S_IDLE, exp_cnt(exp_cycles)}) begin
            errors++;
            $display("FAIL pause_idle: got state=%0d cyc=%0d want state=4 cyc=%0d", state, cycle_cnt, exp_cnt(exp_cycles));
        end
        run = 1'b1;
        tick();
        checks++;
        if (state !== S_FETCH) begin
            errors++;
            $display("FAIL resume_fetch: got state=%0d want %0d", state, S_FETCH);
        end
        run_instr(0, 0, 1'b0, rand_word(), 1'b0);
    endtask

    task automatic test_halt();
        logic [31:0] hw;
        hw = $urandom;
        hw[31:27] = HALT_OPC;
        bus_if.imem_ack = 1'b1; bus_if.imem_data = hw;
        tick();
        bus_if.imem_ack = 1'b0;
        tick();
        exp_cycles += 2;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({state, halted, pc_enable, inst} !== {S_HALTED, 1'b1, 1'b0, hw}) begin
                errors++;
                $display("FAIL halted_hold: got state=%0d halted=%b pc=%b inst=%h want state=5 halted=1 pc=0 inst=%h",
                         state, halted, pc_enable, inst, hw);
            end
            tick();
        end
        checks++;
        if ({cycle_cnt, retired_cnt} !== {exp_cnt(exp_cycles), exp_cnt(exp_retired)}) begin
            errors++;
            $display("FAIL halt_counters: got cyc=%0d ret=%0d want cyc=%0d ret=%0d",
                     cycle_cnt, retired_cnt, exp_cnt(exp_cycles), exp_cnt(exp_retired));
        end
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
        checks++;
        if ({state, pc_enable} !== {S_HALTED, 1'b1}) begin
            errors++;
            $display("FAIL halt_exit_pulse: got state=%0d pc=%b want state=5 pc=1", state, pc_enable);
        end
        tick();
        checks++;
        if ({state, pc_enable, halted} !== {S_FETCH, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL halt_exit_fetch: got state=%0d pc=%b halted=%b want state=0 pc=0 halted=0", state, pc_enable, halted);
        end
        run_instr($urandom_range(0, MAXW - 1), 0, 1'b0, rand_word(), 1'b0);
    endtask

    task automatic test_fault();
        do_reset();
        run = 1'b1;
        tick();
        for (int i = 0; i < int'(MAXW); i++) begin
            checks++;
            if ({state, fault} !== {S_FETCH, 1'b0}) begin
                errors++;
                $display("FAIL wait_fetch: got state=%0d fault=%b want state=0 fault=0 at wait %0d", state, fault, i);
            end
            tick();
        end
        exp_cycles += MAXW;
        repeat (5) begin
            checks++;
            if ({state, fault, bus_if.imem_req, bus_if.exec_start, pc_enable, wb_enable} !== {S_FAULT, 1'b1, 4'd0}) begin
                errors++;
                $display("FAIL fault_sticky: got state=%0d fault=%b strobes=%b%b%b%b want state=6 fault=1 strobes=0000",
                         state, fault, bus_if.imem_req, bus_if.exec_start, pc_enable, wb_enable);
            end
            run = 1'($urandom); bus_if.imem_ack = 1'($urandom); bus_if.exec_done = 1'($urandom);
            tick();
        end
        checks++;
        if (cycle_cnt !== exp_cnt(exp_cycles)) begin
            errors++;
            $display("FAIL fault_cycles: got %0d want %0d", cycle_cnt, exp_cnt(exp_cycles));
        end
        do_reset();
        checks++;
        if ({state, fault} !== {S_IDLE, 1'b0}) begin
            errors++;
            $display("FAIL fault_reset: got state=%0d fault=%b want state=4 fault=0", state, fault);
        end
    endtask

    task automatic test_reset_mid_fetch();
        run = 1'b1;
        tick();
        run_instr(1, 1, 1'b0, rand_word(), 1'b0);
        checks++;
        if (bus_if.imem_req !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_req: got %b want 1", bus_if.imem_req);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus_if.imem_req, state, inst, cycle_cnt, retired_cnt} !== {1'b0, S_IDLE, 32'd0, 64'd0}) begin
            errors++;
            $display("FAIL reset_mid_fetch: got req=%b state=%0d inst=%h cyc=%0d ret=%0d want req=0 state=4 inst=0 cyc=0 ret=0",
                     bus_if.imem_req, state, inst, cycle_cnt, retired_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_min_instr();
        test_delayed();
        test_random();
        test_pause();
        test_halt();
        test_fault();
        test_reset_mid_fetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
